// File: rtl/morse_key_decoder.sv
// Morse key decoder: collects dot/dash symbols, decodes on an inter-character gap to ASCII (A-Z, '?').
// Latency: char_valid rises on the cycle after gap_cnt reaches max(timeout_cycles,1).
// Backpressure: output held until char_ready; a finished character waits in HOLD and new symbols there are dropped (overrun).
// Optional digit table 0-9 enabled by defining MORSE_DECODE_DIGITS_EN.
module morse_key_decoder #(
    parameter int MAX_SYMBOLS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [10:0] key_packet,
    input  logic [31:0] timeout_cycles,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_ascii,
    output logic        overrun,
    output logic        busy
);

    localparam int LW = $clog2(MAX_SYMBOLS + 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LW-1:0]          r_len;
    logic [MAX_SYMBOLS-1:0] r_pattern;
    logic                   r_err;
    logic [31:0]            r_gap_cnt;
    logic                   r_char_valid;
    logic [7:0]             r_char_ascii;
    logic                   r_overrun;

    logic                   w_accept;
    logic                   w_dash;
    logic [31:0]            w_timeout;
    logic                   w_gap_hit;
    logic                   w_can_load;
    logic                   w_len_full;
    logic                   w_append;
    logic                   w_load;
    logic                   w_drop;
    logic [7:0]             w_dec_ascii;

    // Only type 3'b001 with code 1 (dot) or 2 (dash) counts as a symbol.
    assign w_accept   = key_valid && (key_packet[10:8] == 3'b001)
                        && ((key_packet[7:0] == 8'd1) || (key_packet[7:0] == 8'd2));
    assign w_dash     = (key_packet[7:0] == 8'd2);
    // A zero timeout behaves as one cycle; >= lets a lowered timeout fire on the next compare.
    assign w_timeout  = (timeout_cycles == 32'd0) ? 32'd1 : timeout_cycles;
    assign w_gap_hit  = (r_gap_cnt >= w_timeout);
    assign w_can_load = !r_char_valid || char_ready;
    assign w_len_full = (32'(r_len) >= MAX_SYMBOLS);

    assign char_valid = r_char_valid;
    assign char_ascii = r_char_ascii;
    assign overrun    = r_overrun;

    // Table lookup on (len, pattern); pattern is right-aligned, first symbol most significant.
    function automatic logic [7:0] f_decode(input logic [2:0] len, input logic [4:0] pat);
        logic [7:0] ch;
        ch = 8'h3F;
        case ({len, pat})
            {3'd1, 5'b00000}: ch = 8'h45; // E
            {3'd1, 5'b00001}: ch = 8'h54; // T
            {3'd2, 5'b00000}: ch = 8'h49; // I
            {3'd2, 5'b00001}: ch = 8'h41; // A
            {3'd2, 5'b00010}: ch = 8'h4E; // N
            {3'd2, 5'b00011}: ch = 8'h4D; // M
            {3'd3, 5'b00000}: ch = 8'h53; // S
            {3'd3, 5'b00001}: ch = 8'h55; // U
            {3'd3, 5'b00010}: ch = 8'h52; // R
            {3'd3, 5'b00011}: ch = 8'h57; // W
            {3'd3, 5'b00100}: ch = 8'h44; // D
            {3'd3, 5'b00101}: ch = 8'h4B; // K
            {3'd3, 5'b00110}: ch = 8'h47; // G
            {3'd3, 5'b00111}: ch = 8'h4F; // O
            {3'd4, 5'b00000}: ch = 8'h48; // H
            {3'd4, 5'b00001}: ch = 8'h56; // V
            {3'd4, 5'b00010}: ch = 8'h46; // F
            {3'd4, 5'b00100}: ch = 8'h4C; // L
            {3'd4, 5'b00110}: ch = 8'h50; // P
            {3'd4, 5'b00111}: ch = 8'h4A; // J
            {3'd4, 5'b01000}: ch = 8'h42; // B
            {3'd4, 5'b01001}: ch = 8'h58; // X
            {3'd4, 5'b01010}: ch = 8'h43; // C
            {3'd4, 5'b01011}: ch = 8'h59; // Y
            {3'd4, 5'b01100}: ch = 8'h5A; // Z
            {3'd4, 5'b01101}: ch = 8'h51; // Q
`ifdef MORSE_DECODE_DIGITS_EN
            {3'd5, 5'b11111}: ch = 8'h30;
            {3'd5, 5'b01111}: ch = 8'h31;
            {3'd5, 5'b00111}: ch = 8'h32;
            {3'd5, 5'b00011}: ch = 8'h33;
            {3'd5, 5'b00001}: ch = 8'h34;
            {3'd5, 5'b00000}: ch = 8'h35;
            {3'd5, 5'b10000}: ch = 8'h36;
            {3'd5, 5'b11000}: ch = 8'h37;
            {3'd5, 5'b11100}: ch = 8'h38;
            {3'd5, 5'b11110}: ch = 8'h39;
`else
`endif
            default:          ch = 8'h3F;
        endcase
        return ch;
    endfunction

    // Decode the collected character; an overflowed or overlong character is '?'.
    always_comb begin
        w_dec_ascii = 8'h3F;
        if (!r_err && (32'(r_len) <= 32'd5)) begin
            w_dec_ascii = f_decode(3'(r_len), 5'(r_pattern));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: a symbol in the timeout cycle wins over the decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_COLLECT;
            S_COLLECT: if (!w_accept && w_gap_hit) w_state_nxt = w_can_load ? S_IDLE : S_HOLD;
            S_HOLD:    if (w_can_load) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // State outputs: symbol append, output load, overrun drop and busy.
    always_comb begin
        w_append = 1'b0;
        w_load   = 1'b0;
        w_drop   = 1'b0;
        busy     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:    w_append = w_accept;
            S_COLLECT: begin
                w_append = w_accept;
                w_load   = !w_accept && w_gap_hit && w_can_load;
            end
            S_HOLD:    begin
                w_load = w_can_load;
                w_drop = w_accept;
            end
            default:   ;
        endcase
    end

    // Symbol collection and gap timing; a full pattern sets the sticky error instead of shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len     <= '0;
            r_pattern <= '0;
            r_err     <= 1'b0;
            r_gap_cnt <= 32'd0;
        end else if (w_load) begin
            r_len     <= '0;
            r_pattern <= '0;
            r_err     <= 1'b0;
            r_gap_cnt <= 32'd0;
        end else if (w_append) begin
            r_gap_cnt <= 32'd0;
            if (w_len_full) begin
                r_err <= 1'b1;
            end else begin
                r_pattern <= {r_pattern[MAX_SYMBOLS-2:0], w_dash};
                r_len     <= r_len + LW'(1);
            end
        end else if (r_state == S_COLLECT) begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
        end
    end

    // Output register: held until accepted, reloaded back-to-back when a load coincides with accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_char_valid <= 1'b0;
            r_char_ascii <= 8'h00;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_load) begin
                r_char_valid <= 1'b1;
                r_char_ascii <= w_dec_ascii;
            end else if (char_ready) begin
                r_char_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder: expected characters queued at send time, popped on each handshake.
module tb_morse_key_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [10:0] key_packet;
    logic [31:0] timeout_cycles;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_ascii;
    logic        overrun;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb[$];
    int          cv_cnt = 0;
    int          ovr_cnt = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_ascii = 8'h00;

    always #5 clk = ~clk;

    morse_key_decoder #(.MAX_SYMBOLS(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .key_valid      (key_valid),
        .key_packet     (key_packet),
        .timeout_cycles (timeout_cycles),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .char_ascii     (char_ascii),
        .overrun        (overrun),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] t, input logic [7:0] c);
        key_valid  = 1'b1;
        key_packet = {t, c};
        tick(1);
        key_valid  = 1'b0;
        key_packet = 11'd0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(3'b001, (s.getc(i) == 8'h2D) ? 8'd2 : 8'd1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || char_valid) && n < 300) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, busy | char_valid}, 32'd0);
    endtask

    // Monitor: scoreboard pop on handshake, hold stability, overrun pulse count.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (overrun) ovr_cnt++;
            if (prev_hold) begin
                check("hold_valid", {31'd0, char_valid}, 32'd1);
                check("hold_ascii", {24'd0, char_ascii}, {24'd0, prev_ascii});
            end
            if (char_valid && char_ready) begin
                cv_cnt++;
                e = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hFFFF_FFFF;
                check("char_ascii", {24'd0, char_ascii}, e);
            end
            prev_hold  = char_valid && !char_ready;
            prev_ascii = char_ascii;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string      words[4];
        logic [7:0] wexp[4];
        int         c0;
        words = '{"-.-.", "--..", ".---", "-..-"};
        wexp  = '{8'h43, 8'h5A, 8'h4A, 8'h58};

        rst = 1'b1; key_valid = 1'b0; key_packet = 11'd0;
        char_ready = 1'b1; timeout_cycles = 32'd10;
        tick(3);
        check("rst_char_valid", {31'd0, char_valid}, 32'd0);
        check("rst_char_ascii", {24'd0, char_ascii}, 32'd0);
        check("rst_overrun",    {31'd0, overrun},    32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        rst = 1'b0;
        tick(2);

        // 'A': dot, dash three cycles later, character on the cycle after the 10-cycle gap
        sb.push_back(8'h41);
        send(3'b001, 8'd1);
        tick(2);
        send(3'b001, 8'd2);
        check("A_busy", {31'd0, busy}, 32'd1);
        tick(10);
        check("A_not_early", {31'd0, char_valid}, 32'd0);
        tick(1);
        check("A_valid", {31'd0, char_valid}, 32'd1);
        check("A_ascii", {24'd0, char_ascii}, 32'h41);
        tick(1);
        check("A_one_cycle", {31'd0, char_valid}, 32'd0);
        check("A_idle", {31'd0, busy}, 32'd0);

        // Six dots overflow: single '?', no overrun
        sb.push_back(8'h3F);
        send_str("......");
        wait_idle("six_dots_idle");
        check("six_dots_no_overrun", ovr_cnt, 32'd0);
        check("six_dots_drained", sb.size(), 32'd0);

        // Symbol in the timeout cycle is appended: ".-" -> 'A'
        timeout_cycles = 32'd5;
        sb.push_back(8'h41);
        send(3'b001, 8'd1);
        tick(5);
        send(3'b001, 8'd2);
        wait_idle("race_idle");
        check("race_drained", sb.size(), 32'd0);

        // Timeout 0 behaves as 1
        timeout_cycles = 32'd0;
        sb.push_back(8'h54);
        send(3'b001, 8'd2);
        tick(1);
        check("t0_not_early", {31'd0, char_valid}, 32'd0);
        tick(1);
        check("t0_valid", {31'd0, char_valid}, 32'd1);
        check("t0_ascii", {24'd0, char_ascii}, 32'h54);
        wait_idle("t0_idle");

        // Backpressure: 'E' held, 'T' waits in HOLD, dot in HOLD -> overrun
        timeout_cycles = 32'd4;
        char_ready = 1'b0;
        sb.push_back(8'h45);
        sb.push_back(8'h54);
        send(3'b001, 8'd1);
        tick(5);
        check("E_valid", {31'd0, char_valid}, 32'd1);
        check("E_ascii", {24'd0, char_ascii}, 32'h45);
        send(3'b001, 8'd2);
        tick(8);
        check("hold_busy", {31'd0, busy}, 32'd1);
        check("hold_E_ascii", {24'd0, char_ascii}, 32'h45);
        send(3'b001, 8'd1);
        check("overrun_pulse", {31'd0, overrun}, 32'd1);
        tick(1);
        check("overrun_count", ovr_cnt, 32'd1);
        char_ready = 1'b1;
        wait_idle("hold_idle");
        check("hold_drained", sb.size(), 32'd0);
        check("overrun_single", ovr_cnt, 32'd1);

        // Ignored packets: wrong type, wrong code
        timeout_cycles = 32'd10;
        c0 = cv_cnt;
        send(3'b010, 8'd1);
        send(3'b001, 8'd7);
        check("ignore_busy_now", {31'd0, busy}, 32'd0);
        tick(20);
        check("ignore_busy_later", {31'd0, busy}, 32'd0);
        check("ignore_no_char", cv_cnt, c0);

        // Letter variety
        for (int i = 0; i < 4; i++) begin
            sb.push_back(wexp[i]);
            send_str(words[i]);
            wait_idle("letter_idle");
        end
        check("letters_drained", sb.size(), 32'd0);

        // Digit zero: decoded only with the digit table
`ifdef MORSE_DECODE_DIGITS_EN
        sb.push_back(8'h30);
`else
        sb.push_back(8'h3F);
`endif
        send_str("-----");
        wait_idle("digit_idle");
        check("digit_drained", sb.size(), 32'd0);

        // Reset mid-character discards the partial symbols
        c0 = cv_cnt;
        send(3'b001, 8'd1);
        send(3'b001, 8'd2);
        rst = 1'b1;
        tick(2);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, char_valid}, 32'd0);
        rst = 1'b0;
        tick(30);
        check("midrst_no_char", cv_cnt, c0);
        check("midrst_idle", {31'd0, busy}, 32'd0);
        sb.push_back(8'h53);
        send_str("...");
        wait_idle("S_idle");
        check("final_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
